// File: rtl/reorder_buffer.sv
// Reorder buffer: 7-entry circular in-order retirement buffer, tags 1..2^TAG_W-1 (tag 0 = no dependency).
// Latency: issue/write-back take effect at the next edge; a head made ready in cycle N retires in N+1 and commit pulses in N+2.
// Backpressure: issue_ready drops when full, paused or flushing; write-back is never stalled; at most one retirement per cycle.
//
// Ports: clk/rst (async active-low), pause, flush; issue_valid/issue_rd -> issue_ready/issue_tag;
//        wb_valid/wb_tag/wb_data result capture; q1/q2 operand lookup; commit/commit_reg/commit_data/commit_tag
//        registered retire port; count = occupied entries.
// Optional: define ROB_BYPASS_EN to forward a same-cycle write-back onto the query ports.
module reorder_buffer #(
    parameter int TAG_W  = 3,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pause,
    input  logic              flush,
    input  logic              issue_valid,
    input  logic [4:0]        issue_rd,
    output logic              issue_ready,
    output logic [TAG_W-1:0]  issue_tag,
    input  logic              wb_valid,
    input  logic [TAG_W-1:0]  wb_tag,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [TAG_W-1:0]  q1_tag,
    input  logic [TAG_W-1:0]  q2_tag,
    output logic              q1_ready,
    output logic              q2_ready,
    output logic [DATA_W-1:0] q1_value,
    output logic [DATA_W-1:0] q2_value,
    output logic              commit,
    output logic [4:0]        commit_reg,
    output logic [DATA_W-1:0] commit_data,
    output logic [TAG_W-1:0]  commit_tag,
    output logic [TAG_W-1:0]  count
);

    localparam int               DEPTH     = 1 << TAG_W;
    localparam logic [TAG_W-1:0] MAX_TAG   = {TAG_W{1'b1}};
    localparam logic [TAG_W-1:0] FIRST_TAG = {{(TAG_W-1){1'b0}}, 1'b1};

    // Slot 0 exists only so tags index directly; it is never allocated.
    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  ready_q;
    logic [4:0]        rd_q    [DEPTH];
    logic [DATA_W-1:0] value_q [DEPTH];
    logic [TAG_W-1:0]  head_q;
    logic [TAG_W-1:0]  tail_q;
    logic [TAG_W-1:0]  count_q;

    logic do_issue;
    logic do_commit;
    logic wb_hit;

    // Pointers skip tag 0: 1,2,...,MAX,1.
    function automatic logic [TAG_W-1:0] next_tag(input logic [TAG_W-1:0] t);
        return (t == MAX_TAG) ? FIRST_TAG : t + FIRST_TAG;
    endfunction

    // Fullness uses the pre-commit count, so a full buffer refuses issue even while retiring.
    assign issue_ready = (count_q != MAX_TAG) && !flush && !pause;
    assign issue_tag   = tail_q;
    assign count       = count_q;
    assign do_issue    = issue_valid && issue_ready;
    assign do_commit   = !pause && !flush && (count_q != '0) && ready_q[head_q];
    assign wb_hit      = wb_valid && (wb_tag != '0) && valid_q[wb_tag];

    always_comb begin
        q1_ready = 1'b0;
        q1_value = '0;
        q2_ready = 1'b0;
        q2_value = '0;
        if ((q1_tag != '0) && valid_q[q1_tag]) begin
            if (ready_q[q1_tag]) begin
                q1_ready = 1'b1;
                q1_value = value_q[q1_tag];
            end
`ifdef ROB_BYPASS_EN
            if (wb_valid && (wb_tag == q1_tag)) begin
                q1_ready = 1'b1;
                q1_value = wb_data;
            end
`endif
        end
        if ((q2_tag != '0) && valid_q[q2_tag]) begin
            if (ready_q[q2_tag]) begin
                q2_ready = 1'b1;
                q2_value = value_q[q2_tag];
            end
`ifdef ROB_BYPASS_EN
            if (wb_valid && (wb_tag == q2_tag)) begin
                q2_ready = 1'b1;
                q2_value = wb_data;
            end
`endif
        end
    end

    // Payload storage carries no reset; valid/ready bits qualify every read.
    always_ff @(posedge clk) begin
        if (do_issue) begin
            rd_q[tail_q] <= issue_rd;
        end
        if (wb_hit && !flush) begin
            value_q[wb_tag] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q     <= '0;
            ready_q     <= '0;
            head_q      <= FIRST_TAG;
            tail_q      <= FIRST_TAG;
            count_q     <= '0;
            commit      <= 1'b0;
            commit_reg  <= '0;
            commit_data <= '0;
            commit_tag  <= '0;
        end else if (flush) begin
            valid_q <= '0;
            ready_q <= '0;
            head_q  <= FIRST_TAG;
            tail_q  <= FIRST_TAG;
            count_q <= '0;
            commit  <= 1'b0;
        end else begin
            if (wb_hit) begin
                ready_q[wb_tag] <= 1'b1;
            end
            if (do_issue) begin
                valid_q[tail_q] <= 1'b1;
                ready_q[tail_q] <= 1'b0;
                tail_q          <= next_tag(tail_q);
            end
            // Retirement clears last so a stale write-back to the head cannot revive it.
            if (do_commit) begin
                valid_q[head_q] <= 1'b0;
                ready_q[head_q] <= 1'b0;
                head_q          <= next_tag(head_q);
            end
            case ({do_issue, do_commit})
                2'b10:   count_q <= count_q + FIRST_TAG;
                2'b01:   count_q <= count_q - FIRST_TAG;
                default: count_q <= count_q;
            endcase
            // Register 0 is architectural zero: retire silently, keep the last commit payload.
            commit <= do_commit && (rd_q[head_q] != '0);
            if (do_commit && (rd_q[head_q] != '0)) begin
                commit_tag  <= head_q;
                commit_reg  <= rd_q[head_q];
                commit_data <= value_q[head_q];
            end
        end
    end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order retirement buffer, 7 entries, for the tag-based out-of-order core.
- Allocates a 3-bit tag per issued instruction; that tag is the dependency number written into the register file.
- Captures results from the common data bus and answers operand queries from issue.
- Retires results in program order through the register file's commit port (commit/reg_num/data_in/num_in).

Parameters:
- TAG_W, 3, tag width. Tag 0 is reserved for "no dependency"; valid tags are 1..2^TAG_W-1.
- DATA_W, 32, result width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset (rst=0 resets immediately).
- pause  input  1  global stall; blocks issue and commit.
- flush  input  1  synchronous squash of all entries (mispredict).
- issue_valid  input  1  allocate an entry this cycle.
- issue_rd  input  5  destination register of the issuing instruction.
- issue_ready  output  1  combinational; 1 when count<7 and flush=0 and pause=0.
- issue_tag  output  TAG_W  combinational; current tail tag, i.e. the tag that will be allocated.
- wb_valid  input  1  CDB result valid.
- wb_tag  input  TAG_W  CDB result tag.
- wb_data  input  DATA_W  CDB result value.
- q1_tag, q2_tag  input  TAG_W  operand tags to look up.
- q1_ready, q2_ready  output  1  combinational; queried entry is valid and holds its result.
- q1_value, q2_value  output  DATA_W  combinational; stored result, 0 when not ready.
- commit  output  1  registered; one-cycle retire pulse to the register file.
- commit_reg  output  5  registered; retiring destination register.
- commit_data  output  DATA_W  registered; retiring value.
- commit_tag  output  TAG_W  registered; retiring tag.
- count  output  3  number of occupied entries, 0..7.

Behaviour:
- Reset (rst=0, asynchronous):
  - head=tail=1, count=0, every entry valid=0 and ready=0.
  - commit=0, commit_reg=0, commit_data=0, commit_tag=0.
  - Stored entry data is not cleared.
- Tag pointers advance 1→2→…→7→1 and never take the value 0.
- Issue: when issue_valid and issue_ready, the entry at tail gets valid=1, ready=0, rd=issue_rd; then tail++ and count++.
  - If issue_valid=1 and issue_ready=0, the request is ignored and no state changes.
  - Full is judged on count before this cycle's commit, so a full buffer refuses issue even in a cycle where it commits.
- Write-back: when wb_valid and entry[wb_tag] is valid, the entry's value becomes wb_data and ready becomes 1.
  - A write-back with tag 0 or to an invalid entry is ignored.
  - Write-back is accepted during pause; CDB producers never stall.
- Commit, evaluated each cycle when pause=0 and flush=0:
  - If count>0 and entry[head].ready=1: clear valid, head++, count-- (the net count change includes any issue in the same cycle).
  - Next cycle: commit=1, commit_tag=head tag, commit_reg=rd, commit_data=value.
  - If the head's rd=0, the entry retires but commit stays 0, so register 0 is never written.
  - Otherwise commit=0 the next cycle and the other commit outputs hold their last values.
  - At most one retirement per cycle.
- Write-back to the head entry in cycle N makes it eligible in cycle N+1; commit is seen in cycle N+2.
- Simultaneous issue and commit: both take effect and count is unchanged.
- Flush has priority over issue, write-back and commit: all valid and ready bits clear, head=tail=1, count=0, commit=0 next cycle.
- Pause: issue_ready=0, no commit, commit=0 next cycle; head, tail and count are held.
- Query ports: a query with tag 0 returns ready=0, value=0; a query to an invalid entry returns the same.

Optional Feature:
- ROB_BYPASS_EN
  - Defined: a query whose tag equals wb_tag while wb_valid=1 and the entry is valid returns ready=1 and value=wb_data in that same cycle.
  - Undefined: a query sees the result only from the cycle after write-back.

Test Plan:
- Issue rd=5,6,7 → tags 1,2,3, count=3; write-back tag2=0x22 then tag1=0x11 → commit pulses tag1/reg5/0x11 and then tag2/reg6/0x22 on consecutive cycles; tag3 is held until its write-back.
- Issue 7 entries → issue_ready=0, count=7, 8th issue ignored; write-back and retire tag1 → next issue gets tag 1 (wrap-around).
- Issue rd=0 (tag1), write-back 0xAA → head advances, count becomes 0, commit stays 0.
- Full buffer with head ready and issue_valid=1 → retire happens, issue is refused, count=6.
- Assert flush with 4 entries holding mixed ready bits → count=0, issue_tag=1, no commit; assert rst=0 mid-cycle → outputs clear without a clock edge.
- Write-back tag3=0x33 with q1_tag=3 in the same cycle → q1_ready=1, q1_value=0x33 with ROB_BYPASS_EN; q1_ready=0 without it, then 1 the next cycle. Under pause, write-back is still captured and no commit occurs.
